bt_cmd_parser: RTL and testbench
================================

Name: bt_cmd_parser

Overview:
Receive-side counterpart of the Bluetooth UART status reporter. Consumes bytes from the UART receiver and parses ASCII command lines of the form `<key>:<decimal><CR|LF>`. Validated values update the frequency, duty and amplitude configuration registers used by the measurement/generation datapath. Each successful update emits a one-cycle update pulse. Each malformed line emits a one-cycle error pulse carrying an error code.

Parameters:
TIMEOUT_CYC, 5_000_000, inter-byte timeout in clk cycles (100 ms at 50 MHz)
MAX_DIGITS, 7, maximum decimal digits accepted per value
FREQ_RST, 20'd1000, reset value of freq_set
DUTY_RST, 10'd500, reset value of duty_set (units 0.1 %)
AMP_RST, 8'd255, reset value of amp_set

Ports:
clk  in  1  system clock (50 MHz)
rst_n  in  1  asynchronous active-low reset
uart_rx_data  in  8  received byte; valid only when uart_rx_done=1
uart_rx_done  in  1  one-cycle byte strobe
freq_set  out  20  frequency setpoint in Hz, 0..1048575
duty_set  out  10  duty setpoint in 0.1 %, 0..1000
amp_set  out  8  amplitude setpoint, 0..255
cfg_update  out  1  one-cycle pulse when a setpoint is written
cfg_sel  out  2  register written: 0=freq, 1=duty, 2=amp; held until the next update
cmd_err  out  1  one-cycle pulse on a rejected line
err_code  out  3  error code; held until the next cmd_err
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: clk and rst_n, with rst_n asynchronous and active-low.
  - freq_set=FREQ_RST, duty_set=DUTY_RST, amp_set=AMP_RST.
  - cfg_update=0, cfg_sel=0, cmd_err=0, err_code=0, busy=0.
  - State=IDLE, accumulator=0, digit count=0, timeout counter=0.
- Bytes are processed only in cycles where uart_rx_done=1. All outputs are registered.
- States: IDLE, WAIT_COLON, DIGITS, COMMIT, DISCARD.
- IDLE:
  - 'F'/'f' selects freq, 'D'/'d' selects duty, 'A'/'a' selects amp; each goes to WAIT_COLON.
  - CR, LF and space are ignored and stay in IDLE.
  - Any other byte raises error 1 (unknown key) and goes to DISCARD.
- WAIT_COLON:
  - ':' clears the accumulator and digit count, then goes to DIGITS.
  - Any other byte raises error 2 (missing colon). If that byte is CR or LF the next state is IDLE, otherwise DISCARD.
- DIGITS:
  - Byte '0'..'9': acc <= acc*10 + (byte-8'h30). acc is 24 bits wide and saturates at 24'hFFFFFF. The digit count increments.
  - A digit arriving when the count already equals MAX_DIGITS raises error 4 and goes to DISCARD.
  - CR or LF with count=0 raises error 6 (empty value) and goes to IDLE.
  - CR or LF with count>0 goes to COMMIT.
  - Any other byte raises error 3 (non-digit) and goes to DISCARD.
- COMMIT (exactly one cycle, then IDLE):
  - Range limits: freq ≤ 1048575, duty ≤ 1000, amp ≤ 255.
  - In range: write the selected register from acc, set cfg_sel, pulse cfg_update.
  - Out of range: error 5, no register write.
  - Latency: the terminator strobe is sampled at edge k; the setpoint and cfg_update become visible after edge k+1.
  - A uart_rx_done strobe arriving in the COMMIT cycle is processed with IDLE rules. Its transition is taken instead of the COMMIT→IDLE transition; the byte is never dropped.
- DISCARD: ignore all bytes until CR or LF, then go to IDLE. No further cmd_err is raised for the same line.
- Timeout:
  - The counter counts cycles without a strobe while busy=1 and clears on every strobe.
  - On reaching TIMEOUT_CYC-1: error 7, go to IDLE, clear the accumulator.
  - Timeout is checked in DISCARD as well.
- Error reporting: cmd_err is high for exactly one cycle per error. err_code is updated in the same cycle. cmd_err and cfg_update are never high together.
- CRLF pairs: the second terminator of a CR+LF pair is absorbed by IDLE and raises no error.
- Reset mid-line: the partial line is discarded and setpoints return to their reset values immediately.

Decomposition:
- Shared package bt_cmd_pkg holds:
  - State encoding.
  - ASCII constants (CR, LF, ':', space, '0', keys).
  - Error codes: 1 UNKNOWN_KEY, 2 NO_COLON, 3 BAD_CHAR, 4 TOO_LONG, 5 RANGE, 6 EMPTY, 7 TIMEOUT.
  - cfg_sel encoding.
  - Range limit constants.
- Sub-module bt_dec_accum holds the 24-bit saturating multiply-by-10-plus-digit accumulator and the digit counter. Its controls are clear, digit_valid and digit[3:0]; its outputs are acc and count.

Test Plan:
- Send "F:12345\r\n" → after the LF, freq_set=12345, cfg_sel=0, one cfg_update pulse, no cmd_err.
- Send "d:1000\n", then "D:1001\n" → duty_set=1000 with one update; then cmd_err with err_code=5 and duty_set still 1000.
- Send "X:5\r\nA:200\r\n" → cmd_err code 1 and no second error on the same line; then amp_set=200, cfg_sel=2.
- Send "A:\r\n", "F12\n", "F:12a4\n", "F:12345678\n" → error codes 6, 2, 3, 4 respectively; freq_set unchanged.
- Send "F:12" and stop for TIMEOUT_CYC cycles → cmd_err code 7, busy returns to 0; a following "F:7\n" sets freq_set=7.
- Assert rst_n low after "D:25" → all outputs return to reset values; "D:30\n" after release sets duty_set=30.

Source files
------------

// File: rtl/bt_cmd_parser_pkg.sv
// Shared definitions for the Bluetooth command-line parser.
package bt_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_COLON,
    ST_DIGITS,
    ST_COMMIT,
    ST_DISCARD
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE        = 3'd0,
    ERR_UNKNOWN_KEY = 3'd1,
    ERR_NO_COLON    = 3'd2,
    ERR_BAD_CHAR    = 3'd3,
    ERR_TOO_LONG    = 3'd4,
    ERR_RANGE       = 3'd5,
    ERR_EMPTY       = 3'd6,
    ERR_TIMEOUT     = 3'd7
  } err_t;

  typedef enum logic [1:0] {
    SEL_FREQ = 2'd0,
    SEL_DUTY = 2'd1,
    SEL_AMP  = 2'd2
  } sel_t;

  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_NINE  = 8'h39;
  localparam logic [7:0] KEY_F_UC  = 8'h46;
  localparam logic [7:0] KEY_F_LC  = 8'h66;
  localparam logic [7:0] KEY_D_UC  = 8'h44;
  localparam logic [7:0] KEY_D_LC  = 8'h64;
  localparam logic [7:0] KEY_A_UC  = 8'h41;
  localparam logic [7:0] KEY_A_LC  = 8'h61;

  localparam logic [23:0] FREQ_MAX = 24'd1048575;
  localparam logic [23:0] DUTY_MAX = 24'd1000;
  localparam logic [23:0] AMP_MAX  = 24'd255;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASC_ZERO) && (b <= ASC_NINE);
  endfunction

  function automatic logic is_term(input logic [7:0] b);
    return (b == ASC_CR) || (b == ASC_LF);
  endfunction

endpackage

// File: rtl/bt_cmd_parser_if.sv
// Byte stream in, configuration setpoints and status pulses out.
interface bt_cmd_parser_if;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_done;
  logic [19:0] freq_set;
  logic [9:0]  duty_set;
  logic [7:0]  amp_set;
  logic        cfg_update;
  logic [1:0]  cfg_sel;
  logic        cmd_err;
  logic [2:0]  err_code;
  logic        busy;

  modport master (
    output uart_rx_data, uart_rx_done,
    input  freq_set, duty_set, amp_set, cfg_update, cfg_sel, cmd_err, err_code, busy
  );

  modport slave (
    input  uart_rx_data, uart_rx_done,
    output freq_set, duty_set, amp_set, cfg_update, cfg_sel, cmd_err, err_code, busy
  );
endinterface

// File: rtl/bt_dec_accum.sv
// Saturating decimal accumulator (acc*10 + digit) with digit counter.
module bt_dec_accum #(
  parameter int unsigned MAX_DIGITS = 7,
  parameter int unsigned CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_digit_valid,
  input  logic [3:0]       i_digit,
  output logic [23:0]      o_acc,
  output logic [CNT_W-1:0] o_count
);

  logic [23:0]      r_acc;
  logic [CNT_W-1:0] r_count;
  logic [27:0]      w_prod;
  logic [23:0]      w_acc_next;

  // Next accumulator value, clamped to 24 bits.
  always_comb begin
    w_prod     = ({4'b0, r_acc} * 28'd10) + {24'b0, i_digit};
    w_acc_next = (w_prod > 28'h0FF_FFFF) ? '1 : w_prod[23:0];
  end

  // Accumulator and digit-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_acc   <= '0;
      r_count <= '0;
    end else if (i_digit_valid) begin
      r_acc <= w_acc_next;
      if (r_count != '1) r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_acc   = r_acc;
  assign o_count = r_count;

endmodule

// File: rtl/bt_cmd_parser.sv
// Parses "<key>:<decimal><CR|LF>" lines into frequency/duty/amplitude setpoints.
module bt_cmd_parser
  import bt_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 5_000_000,
  parameter int unsigned MAX_DIGITS  = 7,
  parameter logic [19:0] FREQ_RST    = 20'd1000,
  parameter logic [9:0]  DUTY_RST    = 10'd500,
  parameter logic [7:0]  AMP_RST     = 8'd255
) (
  input logic clk,
  input logic rst_n,
  bt_cmd_parser_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_t           r_state, w_next;
  sel_t             r_key, w_key_new;
  logic [TMO_W-1:0] r_tmo;
  logic [19:0]      r_freq;
  logic [9:0]       r_duty;
  logic [7:0]       r_amp;
  logic             r_upd, r_err, r_busy;
  sel_t             r_sel;
  err_t             r_code;

  logic [7:0]       w_byte;
  logic             w_strobe;
  logic [23:0]      w_acc;
  logic [CNT_W-1:0] w_count;
  logic             w_clear, w_dvalid, w_key_load, w_upd, w_err, w_in_range, w_timeout;
  err_t             w_code;

  assign w_byte    = bus.uart_rx_data;
  assign w_strobe  = bus.uart_rx_done;
  assign w_timeout = (r_state != ST_IDLE) && (r_state != ST_COMMIT) && !w_strobe && (r_tmo == TMO_LAST);

  bt_dec_accum #(
    .MAX_DIGITS (MAX_DIGITS),
    .CNT_W      (CNT_W)
  ) u_accum (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_clear       (w_clear),
    .i_digit_valid (w_dvalid),
    .i_digit       (w_byte[3:0]),
    .o_acc         (w_acc),
    .o_count       (w_count)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode, accumulator controls and pulse requests.
  always_comb begin
    w_next     = r_state;
    w_key_new  = r_key;
    w_key_load = 1'b0;
    w_clear    = 1'b0;
    w_dvalid   = 1'b0;
    w_upd      = 1'b0;
    w_err      = 1'b0;
    w_code     = ERR_NONE;
    w_in_range = 1'b0;
    case (r_key)
      SEL_FREQ: w_in_range = (w_acc <= FREQ_MAX);
      SEL_DUTY: w_in_range = (w_acc <= DUTY_MAX);
      SEL_AMP:  w_in_range = (w_acc <= AMP_MAX);
      default:  w_in_range = 1'b0;
    endcase

    unique case (r_state)
      // COMMIT shares IDLE's byte rules so a strobe landing in the commit
      // cycle is never lost; the commit outcome owns that cycle's pulse.
      ST_IDLE, ST_COMMIT: begin
        if (r_state == ST_COMMIT) begin
          w_next = ST_IDLE;
          if (w_in_range) begin
            w_upd = 1'b1;
          end else begin
            w_err  = 1'b1;
            w_code = ERR_RANGE;
          end
        end
        if (w_strobe) begin
          case (w_byte)
            KEY_F_UC, KEY_F_LC: begin
              w_key_load = 1'b1; w_key_new = SEL_FREQ; w_next = ST_WAIT_COLON;
            end
            KEY_D_UC, KEY_D_LC: begin
              w_key_load = 1'b1; w_key_new = SEL_DUTY; w_next = ST_WAIT_COLON;
            end
            KEY_A_UC, KEY_A_LC: begin
              w_key_load = 1'b1; w_key_new = SEL_AMP; w_next = ST_WAIT_COLON;
            end
            ASC_CR, ASC_LF, ASC_SPACE: begin
            end
            default: begin
              w_next = ST_DISCARD;
              if (r_state == ST_IDLE) begin
                w_err  = 1'b1;
                w_code = ERR_UNKNOWN_KEY;
              end
            end
          endcase
        end
      end
      ST_WAIT_COLON: begin
        if (w_strobe) begin
          if (w_byte == ASC_COLON) begin
            w_clear = 1'b1;
            w_next  = ST_DIGITS;
          end else begin
            w_err  = 1'b1;
            w_code = ERR_NO_COLON;
            w_next = is_term(w_byte) ? ST_IDLE : ST_DISCARD;
          end
        end
      end
      ST_DIGITS: begin
        if (w_strobe) begin
          if (is_digit(w_byte)) begin
            if (w_count == CNT_W'(MAX_DIGITS)) begin
              w_err  = 1'b1;
              w_code = ERR_TOO_LONG;
              w_next = ST_DISCARD;
            end else begin
              w_dvalid = 1'b1;
            end
          end else if (is_term(w_byte)) begin
            if (w_count == '0) begin
              w_err  = 1'b1;
              w_code = ERR_EMPTY;
              w_next = ST_IDLE;
            end else begin
              w_next = ST_COMMIT;
            end
          end else begin
            w_err  = 1'b1;
            w_code = ERR_BAD_CHAR;
            w_next = ST_DISCARD;
          end
        end
      end
      ST_DISCARD: begin
        if (w_strobe && is_term(w_byte)) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase

    if (w_timeout) begin
      w_next  = ST_IDLE;
      w_err   = 1'b1;
      w_code  = ERR_TIMEOUT;
      w_clear = 1'b1;
    end
  end

  // Selected key, latched when a key byte is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_key <= SEL_FREQ;
    else if (w_key_load) r_key <= w_key_new;
  end

  // Inter-byte timeout counter, active only mid-line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        r_tmo <= '0;
    else if (w_strobe || r_state == ST_IDLE || w_timeout) r_tmo <= '0;
    else                                               r_tmo <= r_tmo + TMO_W'(1);
  end

  // Registered setpoints, pulses and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_freq <= FREQ_RST;
      r_duty <= DUTY_RST;
      r_amp  <= AMP_RST;
      r_upd  <= 1'b0;
      r_err  <= 1'b0;
      r_sel  <= SEL_FREQ;
      r_code <= ERR_NONE;
      r_busy <= 1'b0;
    end else begin
      r_upd  <= w_upd;
      r_err  <= w_err;
      r_busy <= (w_next != ST_IDLE);
      if (w_err) r_code <= w_code;
      if (w_upd) begin
        r_sel <= r_key;
        case (r_key)
          SEL_FREQ: r_freq <= w_acc[19:0];
          SEL_DUTY: r_duty <= w_acc[9:0];
          SEL_AMP:  r_amp  <= w_acc[7:0];
          default:  r_freq <= r_freq;
        endcase
      end
    end
  end

  assign bus.freq_set   = r_freq;
  assign bus.duty_set   = r_duty;
  assign bus.amp_set    = r_amp;
  assign bus.cfg_update = r_upd;
  assign bus.cfg_sel    = r_sel;
  assign bus.cmd_err    = r_err;
  assign bus.err_code   = r_code;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_bt_cmd_parser.sv
// Self-checking bench: directed lines plus random lines against a line-level model.
module tb_bt_cmd_parser;

  localparam int unsigned TMO = 300;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  bt_cmd_parser_if bus();

  bt_cmd_parser #(.TIMEOUT_CYC(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] dut_q[$];
  logic [31:0] exp_q[$];
  logic [7:0]  seg[$];
  logic [19:0] m_freq = 20'd1000;
  logic [9:0]  m_duty = 10'd500;
  logic [7:0]  m_amp  = 8'd255;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Event monitor: every update or error pulse becomes one queue entry.
  always @(negedge clk) begin
    if (rst_n && (bus.cfg_update || bus.cmd_err)) begin
      check_val("upd_err_exclusive", {31'b0, bus.cfg_update & bus.cmd_err}, 32'd0);
      if (bus.cfg_update) begin
        case (bus.cfg_sel)
          2'd0:    dut_q.push_back({8'hA0, 4'h0, bus.freq_set});
          2'd1:    dut_q.push_back({8'hA1, 14'h0, bus.duty_set});
          2'd2:    dut_q.push_back({8'hA2, 16'h0, bus.amp_set});
          default: dut_q.push_back({8'hAF, 24'h0});
        endcase
      end
      if (bus.cmd_err) dut_q.push_back({5'b11100, bus.err_code, 24'h0});
    end
  end

  // Model: evaluate one complete line (bytes between terminators).
  task automatic eval_seg();
    int n = seg.size();
    int i = 0;
    int sel;
    int cnt = 0;
    longint val = 0;
    longint lim;
    logic [7:0] c;
    while (i < n && seg[i] == 8'h20) i++;
    if (i == n) return;
    c = seg[i];
    if (c == "F" || c == "f") sel = 0;
    else if (c == "D" || c == "d") sel = 1;
    else if (c == "A" || c == "a") sel = 2;
    else begin exp_q.push_back({8'hE1, 24'h0}); return; end
    i++;
    if (i == n || seg[i] != 8'h3A) begin exp_q.push_back({8'hE2, 24'h0}); return; end
    i++;
    for (; i < n; i++) begin
      c = seg[i];
      if (c >= 8'h30 && c <= 8'h39) begin
        if (cnt == 7) begin exp_q.push_back({8'hE4, 24'h0}); return; end
        val = val * 10 + longint'(c - 8'h30);
        cnt++;
      end else begin
        exp_q.push_back({8'hE3, 24'h0});
        return;
      end
    end
    if (cnt == 0) begin exp_q.push_back({8'hE6, 24'h0}); return; end
    lim = (sel == 0) ? 1048575 : (sel == 1) ? 1000 : 255;
    if (val > lim) begin exp_q.push_back({8'hE5, 24'h0}); return; end
    case (sel)
      0: m_freq = 20'(val);
      1: m_duty = 10'(val);
      default: m_amp = 8'(val);
    endcase
    exp_q.push_back({8'hA0 | 8'(sel), 24'(val)});
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'h0D || b == 8'h0A) begin
      eval_seg();
      seg.delete();
    end else begin
      seg.push_back(b);
    end
  endtask

  // Called at a negedge; returns at a negedge after the strobe plus gap idle cycles.
  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    bus.uart_rx_data = b;
    bus.uart_rx_done = 1'b1;
    model_byte(b);
    @(negedge clk);
    bus.uart_rx_done = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_str(input string s, input int unsigned gap);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
  endtask

  task automatic compare_events(input string tag);
    repeat (4) @(negedge clk);
    check_val({tag, "_nev"}, dut_q.size(), exp_q.size());
    for (int i = 0; i < dut_q.size() && i < exp_q.size(); i++)
      check_val({tag, "_ev"}, dut_q[i], exp_q[i]);
    dut_q.delete();
    exp_q.delete();
  endtask

  task automatic check_regs(input string tag);
    check_val({tag, "_freq"}, {12'h0, bus.freq_set}, {12'h0, m_freq});
    check_val({tag, "_duty"}, {22'h0, bus.duty_set}, {22'h0, m_duty});
    check_val({tag, "_amp"},  {24'h0, bus.amp_set},  {24'h0, m_amp});
    check_val({tag, "_busy"}, {31'h0, bus.busy}, 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_freq"}, {12'h0, bus.freq_set}, 32'd1000);
    check_val({tag, "_duty"}, {22'h0, bus.duty_set}, 32'd500);
    check_val({tag, "_amp"},  {24'h0, bus.amp_set},  32'd255);
    check_val({tag, "_pulses"}, {30'h0, bus.cfg_update, bus.cmd_err}, 32'd0);
    check_val({tag, "_sel_code"}, {27'h0, bus.cfg_sel, bus.err_code}, 32'd0);
    check_val({tag, "_busy"}, {31'h0, bus.busy}, 32'd0);
  endtask

  task automatic random_line();
    logic [7:0] q[$];
    string keys = "FfDdAaXq";
    string junk = "x.-/ G";
    int unsigned kidx, nd, t;
    if ($urandom_range(0, 7) == 0) q.push_back(8'h20);
    kidx = $urandom_range(0, 7);
    q.push_back(keys[kidx]);
    if ($urandom_range(0, 9) != 0) q.push_back(8'h3A);
    else q.push_back(junk[$urandom_range(0, 5)]);
    nd = (kidx < 2 || kidx > 5) ? $urandom_range(0, 8) : $urandom_range(0, 4);
    for (int d = 0; d < int'(nd); d++) begin
      if ($urandom_range(0, 19) == 0) q.push_back(junk[$urandom_range(0, 5)]);
      else q.push_back(8'h30 + 8'($urandom_range(0, 9)));
    end
    foreach (q[i]) send_byte(q[i], $urandom_range(1, 3));
    t = $urandom_range(0, 2);
    if (t == 0) send_byte(8'h0D, 2);
    else if (t == 1) send_byte(8'h0A, 2);
    else begin
      send_byte(8'h0D, $urandom_range(0, 1));
      send_byte(8'h0A, 2);
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned waited;
    bit seen;
    bus.uart_rx_data = '0;
    bus.uart_rx_done = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Commit latency: terminator sampled at edge k, update visible after k+1.
    send_str("F:12345", 1);
    send_byte(8'h0D, 0);
    check_val("lat_k_upd", {31'h0, bus.cfg_update}, 32'd0);
    check_val("lat_k_freq", {12'h0, bus.freq_set}, 32'd1000);
    @(negedge clk);
    check_val("lat_k1_upd", {31'h0, bus.cfg_update}, 32'd1);
    check_val("lat_k1_freq", {12'h0, bus.freq_set}, 32'd12345);
    check_val("lat_k1_sel", {30'h0, bus.cfg_sel}, 32'd0);
    send_byte(8'h0A, 2);
    compare_events("f12345");
    check_regs("f12345");

    send_str("d:1000\012", 1);
    send_str("D:1001\012", 1);
    compare_events("duty_range");
    check_regs("duty_range");

    send_str("X:5\015\012A:200\015\012", 1);
    compare_events("unknown_then_amp");
    check_val("amp_sel", {30'h0, bus.cfg_sel}, 32'd2);
    check_regs("unknown_then_amp");

    send_str("A:\015\012", 1);
    send_str("F12\012", 1);
    send_str("F:12a4\012", 1);
    send_str("F:12345678\012", 1);
    compare_events("err_codes");
    check_regs("err_codes");

    // Timeout mid-line.
    send_str("F:12", 1);
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < TMO + 20) begin
      @(negedge clk);
      waited++;
      if (bus.cmd_err) seen = 1'b1;
    end
    check_val("tmo_seen", {31'h0, seen}, 32'd1);
    check_val("tmo_window", {31'h0, (waited + 3 >= TMO) && (waited <= TMO + 3)}, 32'd1);
    seg.delete();
    exp_q.push_back({8'hE7, 24'h0});
    compare_events("timeout");
    check_regs("timeout");
    send_str("F:7\012", 1);
    compare_events("after_tmo");
    check_regs("after_tmo");

    // Reset mid-line.
    send_str("D:25", 1);
    compare_events("pre_reset");
    rst_n = 1'b0;
    #1;
    seg.delete();
    m_freq = 20'd1000;
    m_duty = 10'd500;
    m_amp  = 8'd255;
    check_reset_state("midline_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_str("D:30\012", 1);
    compare_events("after_reset");
    check_regs("after_reset");

    for (int n = 0; n < 200; n++) begin
      random_line();
      compare_events("rand");
      check_regs("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
